// File: rtl/line_loader.sv
// Serial-to-parallel line loader: assembles 25-bit lines MSB-first from a bit
// stream, double-buffers one completed line, and issues init/firstread pulses.
module line_loader #(
  parameter int memsize = 25,
  parameter int cntw    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         num_lines,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic               mem_busy,
  output logic [memsize-1:0] line,
  output logic               init,
  output logic               firstread,
  output logic               busy,
  output logic               done,
  output logic [7:0]         lines_issued
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [cntw-1:0] last_idx = cntw'(memsize - 1);

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         num_q;
  logic [7:0]         recv_cnt;
  logic [cntw-1:0]    cnt;
  logic [memsize-1:0] sr;
  logic [memsize-1:0] sr_nxt;
  logic [memsize-1:0] hold;
  logic               hold_full;
  logic               issue;
  logic               last_bit;
  logic               take;

  // The issue decision is shared by bit_ready so that a line completing in the
  // same cycle the hold buffer drains does not stall.
  always_comb begin
    issue     = (state == RUN) && hold_full && !mem_busy && !init && !firstread;
    last_bit  = (cnt == last_idx);
    bit_ready = (state == RUN) && (recv_cnt < num_q) &&
                !(last_bit && hold_full && !issue);
    take      = bit_valid && bit_ready;
    sr_nxt    = {sr[memsize-2:0], bit_in};
    busy      = (state == RUN);
    done      = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if ((lines_issued == num_q) && !hold_full) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value (line <= hold picks up the old
  // line even when a new one lands in hold on the same edge).
  // The hold buffer is a plain register, so it is cleared with everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_q        <= '0;
      recv_cnt     <= '0;
      cnt          <= '0;
      sr           <= '0;
      hold         <= '0;
      hold_full    <= 1'b0;
      line         <= '0;
      init         <= 1'b0;
      firstread    <= 1'b0;
      lines_issued <= '0;
    end else begin
      init      <= issue;
      firstread <= init;

      if ((state == IDLE) && start) begin
        num_q        <= num_lines;
        lines_issued <= '0;
        recv_cnt     <= '0;
        cnt          <= '0;
        sr           <= '0;
      end

      if (take) begin
        sr <= sr_nxt;
        if (last_bit) begin
          cnt      <= '0;
          hold     <= sr_nxt;
          recv_cnt <= recv_cnt + 8'd1;
        end else begin
          cnt <= cnt + cntw'(1);
        end
      end

      if (take && last_bit) hold_full <= 1'b1;
      else if (issue)       hold_full <= 1'b0;

      if (issue) begin
        line         <= hold;
        lines_issued <= lines_issued + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_loader.sv
// Randomized bench for line_loader: a line-level scoreboard rebuilds expected
// lines from the accepted bit stream and checks each init against it.
module tb_line_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_lines = 8'd0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic        mem_busy = 1'b0;
  logic [24:0] line;
  logic        init;
  logic        firstread;
  logic        busy;
  logic        done;
  logic [7:0]  lines_issued;

  line_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_lines    (num_lines),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .mem_busy     (mem_busy),
    .line         (line),
    .init         (init),
    .firstread    (firstread),
    .busy         (busy),
    .done         (done),
    .lines_issued (lines_issued)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard state: accepted bits are packed MSB-first into whole lines.
  logic [24:0] acc;
  int          nb;
  logic [24:0] exp_q[$];
  int          init_cnt, done_cnt, bits_acc;
  int          first_init_cyc, last_init_cyc, done_cyc, acc_cyc, start_cyc;
  logic        prev_init = 1'b0;
  logic        stop_busy;

  always @(negedge clk) begin
    if (rst) begin
      if (bit_valid && bit_ready) begin
        acc = {acc[23:0], bit_in};
        nb++;
        bits_acc++;
        if (nb == 25) begin
          exp_q.push_back(acc);
          nb = 0;
        end
      end
      if (prev_init || firstread) begin
        n_checks++;
        if (firstread !== prev_init)
          $display("FAIL firstread_follows_init: firstread=%b init_prev=%b at cyc %0d", firstread, prev_init, cyc);
        else n_pass++;
      end
      if (init) begin
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL line_order: init with line=%h, expected no line", line);
        else begin
          logic [24:0] exp_line;
          exp_line = exp_q.pop_front();
          if (line !== exp_line) $display("FAIL line_order: line=%h want %h", line, exp_line);
          else n_pass++;
        end
        if (init_cnt > 0) begin
          n_checks++;
          if (cyc - last_init_cyc < 2)
            $display("FAIL init_spacing: %0d cycles, want >= 2", cyc - last_init_cyc);
          else n_pass++;
        end
        if (init_cnt == 0) first_init_cyc = cyc;
        last_init_cyc = cyc;
        init_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_init = init;
    end else begin
      prev_init = 1'b0;
    end
  end

  task automatic clear_model();
    acc = '0; nb = 0; exp_q.delete();
    init_cnt = 0; done_cnt = 0; bits_acc = 0;
    first_init_cyc = -1; last_init_cyc = -1; done_cyc = -1;
  endtask

  task automatic start_run(input logic [7:0] n);
    clear_model();
    start = 1'b1;
    num_lines = n;
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int max_wait, input string tag);
    bit ok = 1'b0;
    bit_valid = 1'b1;
    bit_in = b;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (bit_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL %s: bit_ready=0 for %0d cycles, want 1", tag, max_wait);
    else n_pass++;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [24:0] v, input int hi, input int lo,
                           input int max_wait, input int gap_max, input string tag);
    for (int i = hi; i >= lo; i--) begin
      send_bit(v[i], max_wait, tag);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int max, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL %s: done not seen within %0d cycles", tag, max);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({line, init, firstread, bit_ready, busy, done, lines_issued} !== '0)
      $display("FAIL %s: line=%h init=%b fr=%b rdy=%b busy=%b done=%b issued=%0d, want all 0",
               tag, line, init, firstread, bit_ready, busy, done, lines_issued);
    else n_pass++;
  endtask

  task automatic test_reset();
    clear_model();
    rst = 1'b1;
    #3 rst = 1'b0;
    #4 check_idle_outputs("reset_async");
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("reset_held");
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_release");
  endtask

  task automatic test_single();
    start_run(8'd1);
    send_bits(25'h1000001, 24, 0, 1, 0, "single_ready");
    wait_done(20, "single_done");
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (first_init_cyc !== acc_cyc + 2)
      $display("FAIL single_latency: init at cyc %0d want %0d", first_init_cyc, acc_cyc + 2);
    else n_pass++;
    n_checks++;
    if (line !== 25'h1000001) $display("FAIL single_line: line=%h want 1000001", line);
    else n_pass++;
    n_checks++;
    if (lines_issued !== 8'd1 || init_cnt != 1)
      $display("FAIL single_count: issued=%0d inits=%0d want 1/1", lines_issued, init_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || busy !== 1'b0)
      $display("FAIL single_done_pulse: done cycles=%0d busy=%b want 1/0", done_cnt, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [24:0] l1;
    l1 = 25'($urandom);
    start_run(8'd2);
    send_bits(l1, 24, 0, 1, 0, "b2b_ready");
    send_bits(25'h1FFFFFF, 24, 0, 1, 0, "b2b_ready");
    wait_done(20, "b2b_done");
    n_checks++;
    if (init_cnt != 2 || lines_issued !== 8'd2)
      $display("FAIL b2b_count: inits=%0d issued=%0d want 2/2", init_cnt, lines_issued);
    else n_pass++;
    n_checks++;
    if (line !== 25'h1FFFFFF) $display("FAIL b2b_line2: line=%h want 1ffffff", line);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [24:0] l1, l2, l3;
    int busy_start, fall_cyc, ready_seen;
    l1 = 25'($urandom); l2 = 25'($urandom); l3 = 25'($urandom);
    mem_busy = 1'b1;
    start_run(8'd3);
    busy_start = cyc;
    send_bits(l1, 24, 0, 1, 0, "stall_ready");
    send_bits(l2, 24, 1, 1, 0, "stall_ready");
    bit_valid = 1'b1;
    bit_in = l2[0];
    ready_seen = 0;
    while (cyc - busy_start < 80) begin
      @(negedge clk);
      if (bit_ready) ready_seen++;
    end
    @(posedge clk); #1;
    bit_valid = 1'b0;
    n_checks++;
    if (ready_seen != 0 || bits_acc != 49)
      $display("FAIL stall_ready_low: ready cycles=%0d accepted=%0d want 0/49", ready_seen, bits_acc);
    else n_pass++;
    n_checks++;
    if (init_cnt != 0 || lines_issued !== 8'd0)
      $display("FAIL stall_no_issue: inits=%0d issued=%0d want 0/0", init_cnt, lines_issued);
    else n_pass++;
    mem_busy = 1'b0;
    fall_cyc = cyc;
    send_bit(l2[0], 5, "stall_resume");
    send_bits(l3, 24, 0, 5, 0, "stall_resume");
    wait_done(30, "stall_done");
    n_checks++;
    if (first_init_cyc !== fall_cyc + 1)
      $display("FAIL stall_release: init at cyc %0d want %0d", first_init_cyc, fall_cyc + 1);
    else n_pass++;
    n_checks++;
    if (init_cnt != 3 || lines_issued !== 8'd3)
      $display("FAIL stall_count: inits=%0d issued=%0d want 3/3", init_cnt, lines_issued);
    else n_pass++;
  endtask

  task automatic test_zero_lines();
    bit_valid = 1'b1;
    bit_in = 1'b1;
    start_run(8'd0);
    wait_done(10, "zero_done");
    repeat (3) @(posedge clk);
    #1 bit_valid = 1'b0;
    n_checks++;
    if (done_cyc !== start_cyc + 1)
      $display("FAIL zero_done_time: done at cyc %0d want %0d", done_cyc, start_cyc + 1);
    else n_pass++;
    n_checks++;
    if (init_cnt != 0 || bits_acc != 0 || lines_issued !== 8'd0)
      $display("FAIL zero_idle: inits=%0d bits=%0d issued=%0d want 0/0/0", init_cnt, bits_acc, lines_issued);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [24:0] l1, l2, l3;
    l1 = 25'($urandom) | 25'h1; l2 = 25'($urandom); l3 = 25'($urandom);
    start_run(8'd2);
    send_bits(l1, 24, 0, 1, 0, "mid_ready");
    send_bits(l2, 24, 13, 1, 0, "mid_ready");
    rst = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_run(8'd1);
    send_bits(l3, 24, 0, 1, 1, "mid_new_ready");
    wait_done(20, "mid_done");
    n_checks++;
    if (line !== l3 || lines_issued !== 8'd1)
      $display("FAIL mid_fresh_line: line=%h issued=%0d want %h/1", line, lines_issued, l3);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [24:0] l1, l2;
    l1 = 25'($urandom); l2 = 25'($urandom);
    start_run(8'd2);
    send_bits(l1, 24, 15, 1, 2, "ign_ready");
    start = 1'b1;
    num_lines = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    send_bits(l1, 14, 0, 5, 2, "ign_ready");
    send_bits(l2, 24, 0, 5, 2, "ign_ready");
    wait_done(20, "ign_done");
    n_checks++;
    if (lines_issued !== 8'd2 || init_cnt != 2 || busy !== 1'b0 || bit_ready !== 1'b0)
      $display("FAIL ign_count: issued=%0d inits=%0d busy=%b rdy=%b want 2/2/0/0",
               lines_issued, init_cnt, busy, bit_ready);
    else n_pass++;
  endtask

  task automatic test_random_busy();
    int n;
    n = $urandom_range(3, 5);
    stop_busy = 1'b0;
    start_run(8'(n));
    fork
      while (!stop_busy) begin
        @(posedge clk); #1;
        mem_busy = ($urandom_range(0, 2) == 0);
      end
    join_none
    for (int k = 0; k < n; k++) send_bits(25'($urandom), 24, 0, 200, 2, "rnd_ready");
    wait_done(300, "rnd_done");
    stop_busy = 1'b1;
    @(posedge clk); #2;
    mem_busy = 1'b0;
    n_checks++;
    if (init_cnt != n || lines_issued !== 8'(n))
      $display("FAIL rnd_count: inits=%0d issued=%0d want %0d", init_cnt, lines_issued, n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero_lines();
    test_reset_mid_run();
    test_start_ignored();
    test_random_busy();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
